control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Initiator side of the datapath control handshake: drives start/mode into the control unit and consumes its done indication.
- Buffers queued operation requests (1-bit mode each) in a small FIFO and issues them one at a time.
- Waits for done on each operation, with a watchdog timeout.
- Counts completed operations and flags protocol errors.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of 2, minimum 2.
- TIMEOUT, 8, maximum WAIT-state clock edges without done before the job is abandoned; minimum 2.
- CNT_W, 8, width of the completion counter.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  request to enqueue one operation.
- cmd_mode  in  1  mode bit for the enqueued operation.
- cmd_ready  out  1  FIFO not full; a push occurs when cmd_valid && cmd_ready at a clock edge.
- start  out  1  one-cycle request pulse to the control unit.
- mode  out  1  mode of the in-flight operation; stable from start through done.
- done  in  1  completion level from the control unit.
- err_clear  in  1  clears both sticky error flags.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  sticky: a job was abandoned by the watchdog.
- err_spurious  out  1  sticky: done was sampled high in IDLE or ISSUE.
- completed_count  out  CNT_W  number of jobs finished with done; wraps modulo 2^CNT_W.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values, applied asynchronously:
  - State IDLE; FIFO empty, pointers 0, fifo_level 0, cmd_ready 1.
  - start 0, mode 0, busy 0.
  - err_timeout 0, err_spurious 0, completed_count 0, watchdog timer 0.
- Reset mid-operation drops the in-flight job and all queued jobs. No start is issued until a new push.
- FIFO:
  - cmd_ready = (fifo_level != DEPTH), combinational from occupancy.
  - A push while full is impossible; cmd_valid is ignored.
  - Pop occurs on the ISSUE->WAIT edge.
  - Push and pop on the same edge: level unchanged; both take effect.
  - Pointers wrap modulo DEPTH.
- State machine (registered state; start, mode and busy are decoded from registered state/registers, so they are glitch-free):
  - IDLE: FIFO non-empty -> ISSUE, and load the mode register from the FIFO head. Otherwise stay in IDLE.
  - ISSUE: start=1 for exactly this one cycle. At the next edge: pop the FIFO, clear the timer, -> WAIT.
  - WAIT:
    - Each edge with done=1: completed_count += 1, -> GAP.
    - Each edge with done=0: timer += 1.
    - If the timer reaches TIMEOUT: set err_timeout, do not count the job, -> GAP.
  - GAP: stay while done=1. On the first edge sampling done=0 -> IDLE. This guarantees the done level from one job is never attributed to the next.
- mode holds its value from the IDLE->ISSUE edge until the next IDLE->ISSUE edge.
- Latency from a push into an empty FIFO while in IDLE:
  - Push at edge E0; ISSUE at E1; start high during E1..E2.
  - WAIT entered at E2; the first done sample is at E3.
- Back-to-back jobs: minimum start-to-start spacing is 4 cycles (ISSUE, WAIT>=1, GAP>=1, IDLE).
- err_spurious is set at any edge with done=1 while in IDLE or ISSUE. Such a done is otherwise ignored and is not counted.
- err_clear: clears both flags at the edge. If a set condition occurs on the same edge, the set wins.
- completed_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Single job: push mode=1 at E0 -> start=1 only in cycle E1..E2, mode=1. Responder raises done during the cycle ending at E5 -> completed_count=1, busy low after GAP, fifo_level back to 0.
- Queue fill: push 5 jobs back-to-back with DEPTH=4 while the FSM is blocked in WAIT -> cmd_ready=0 after 4 occupied, the 5th is not accepted. Jobs issue in order with modes 0,1,1,0 as pushed.
- Timeout: issue a job and never assert done -> after 8 WAIT edges err_timeout=1, completed_count unchanged. The next queued job still issues. err_clear -> err_timeout=0.
- Stuck done: hold done=1 for 6 cycles after completion -> FSM stays in GAP, no new start. Count increments once. err_spurious stays 0.
- Spurious done: assert done in IDLE -> err_spurious=1, count 0. Simultaneous err_clear and spurious done -> flag stays 1.
- Reset mid-WAIT with 3 jobs queued -> start=0, fifo_level=0, busy=0, completed_count=0 immediately. No start until a new push. Also cover count wrap with CNT_W=2: the 5th completion gives 1.

Source files
------------

// File: rtl/control_sequencer.sv
// Initiator for the control-unit start/done handshake: queues 1-bit mode requests and issues them one at a time.
// Includes a done watchdog, a wrapping completion counter and sticky protocol-error flags.

module control_sequencer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wr_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rd_dat_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [LVL_W-1:0] level_q;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wr_dat_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      if (push_i && !pop_i) begin
        level_q <= level_q + LVL_W'(1);
      end else if (pop_i && !push_i) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

  assign rd_dat_o = mem_q[rd_q];
  assign level_o  = level_q;
  assign full_o   = (level_q == LVL_W'(DEPTH));
  assign empty_o  = (level_q == '0);
endmodule

module control_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic                   cmd_mode,
  output logic                   cmd_ready,
  output logic                   start,
  output logic                   mode,
  input  logic                   done,
  input  logic                   err_clear,
  output logic                   busy,
  output logic                   err_timeout,
  output logic                   err_spurious,
  output logic [CNT_W-1:0]       completed_count,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t           state_q;
  logic             mode_q;
  logic [TMR_W-1:0] timer_q;
  logic [CNT_W-1:0] count_q;
  logic             err_to_q;
  logic             err_sp_q;

  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic push;
  logic pop;

  assign push = cmd_valid && !fifo_full;
  assign pop  = (state_q == S_ISSUE);

  control_sequencer_fifo #(.DEPTH(DEPTH), .WIDTH(1)) u_cmd_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_i   (push),
    .wr_dat_i (cmd_mode),
    .pop_i    (pop),
    .rd_dat_o (fifo_head),
    .level_o  (fifo_level),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      timer_q  <= '0;
      count_q  <= '0;
      err_to_q <= 1'b0;
      err_sp_q <= 1'b0;
    end else begin
      // Clear first so a same-edge set condition overrides it.
      if (err_clear) begin
        err_to_q <= 1'b0;
        err_sp_q <= 1'b0;
      end
      if (done && (state_q == S_IDLE || state_q == S_ISSUE)) begin
        err_sp_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            mode_q  <= fifo_head;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            count_q <= count_q + CNT_W'(1);
            state_q <= S_GAP;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
            if (timer_q == TMR_W'(TIMEOUT - 1)) begin
              err_to_q <= 1'b1;
              state_q  <= S_GAP;
            end
          end
        end
        S_GAP: begin
          // Hold off until done drops so a lingering level is never credited to the next job.
          if (!done) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready       = !fifo_full;
  assign start           = (state_q == S_ISSUE);
  assign busy            = (state_q != S_IDLE);
  assign mode            = mode_q;
  assign err_timeout     = err_to_q;
  assign err_spurious    = err_sp_q;
  assign completed_count = count_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vector table, hand-written corner sequences and random traffic vs a queue-based model.
// A second instance with a 2-bit counter shares all stimulus to exercise counter wrap.

module tb_control_sequencer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic       clock, reset, cmd_valid, cmd_mode, done, err_clear;
  logic       cmd_ready, start, mode, busy, err_timeout, err_spurious;
  logic [7:0] completed_count;
  logic [2:0] fifo_level;
  logic       w_cmd_ready, w_start, w_mode, w_busy, w_err_timeout, w_err_spurious;
  logic [1:0] w_count;
  logic [2:0] w_fifo_level;

  control_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode),
    .cmd_ready(cmd_ready), .start(start), .mode(mode), .done(done),
    .err_clear(err_clear), .busy(busy), .err_timeout(err_timeout),
    .err_spurious(err_spurious), .completed_count(completed_count), .fifo_level(fifo_level)
  );

  control_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(2)) dut_w (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode),
    .cmd_ready(w_cmd_ready), .start(w_start), .mode(w_mode), .done(done),
    .err_clear(err_clear), .busy(w_busy), .err_timeout(w_err_timeout),
    .err_spurious(w_err_spurious), .completed_count(w_count), .fifo_level(w_fifo_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of pending modes plus the phase of the current job.
  localparam int ST_IDLE = 0, ST_ISSUE = 1, ST_WAIT = 2, ST_GAP = 3;
  bit m_q[$];
  int m_stage;
  bit m_mode;
  int m_waited;
  int m_jobs;
  bit m_to, m_sp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_stage = ST_IDLE; m_mode = 0; m_waited = 0; m_jobs = 0; m_to = 0; m_sp = 0;
  endtask

  task automatic model_edge();
    bit do_push;
    do_push = cmd_valid && (m_q.size() < DEPTH);
    if (err_clear) begin m_to = 0; m_sp = 0; end
    if (done && (m_stage == ST_IDLE || m_stage == ST_ISSUE)) m_sp = 1;
    case (m_stage)
      ST_IDLE:  if (m_q.size() > 0) begin m_mode = m_q[0]; m_stage = ST_ISSUE; end
      ST_ISSUE: begin void'(m_q.pop_front()); m_waited = 0; m_stage = ST_WAIT; end
      ST_WAIT: begin
        if (done) begin m_jobs++; m_stage = ST_GAP; end
        else begin
          m_waited++;
          if (m_waited == TIMEOUT) begin m_to = 1; m_stage = ST_GAP; end
        end
      end
      default:  if (!done) m_stage = ST_IDLE;
    endcase
    if (do_push) m_q.push_back(cmd_mode);
  endtask

  task automatic check_all();
    logic [7:0] exp_flags;
    exp_flags = {m_stage == ST_ISSUE, m_stage != ST_IDLE, m_mode, m_q.size() < DEPTH,
                 m_to, m_sp, 2'b00};
    chk("start", start, m_stage == ST_ISSUE);
    chk("busy", busy, m_stage != ST_IDLE);
    chk("mode", mode, m_mode);
    chk("fifo_level", fifo_level, m_q.size());
    chk("cmd_ready", cmd_ready, m_q.size() < DEPTH);
    chk("completed_count", completed_count, m_jobs % 256);
    chk("err_timeout", err_timeout, m_to);
    chk("err_spurious", err_spurious, m_sp);
    chk("w2_count", w_count, m_jobs % 4);
    chk("w2_flags", {w_start, w_busy, w_mode, w_cmd_ready, w_err_timeout, w_err_spurious, 2'b00},
        exp_flags);
    chk("w2_level", w_fifo_level, m_q.size());
  endtask

  task automatic drive(input bit v, input bit m, input bit d, input bit c);
    cmd_valid = v; cmd_mode = m; done = d; err_clear = c;
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 0);
  endtask

  // Responder that answers done on the first WAIT sample; logs the mode of every start seen.
  task automatic serve(input int cycles, inout bit got[$]);
    for (int i = 0; i < cycles; i++) begin
      drive(0, 0, m_stage == ST_WAIT, 0);
      step();
      if (start) got.push_back(mode);
    end
  endtask

  typedef struct {
    bit v, m, d, c;
    bit e_start, e_busy, e_mode;
    int e_level, e_count;
    bit e_sp;
  } vec_t;

  vec_t tbl[10];
  bit   fill_modes[5];
  bit   exp_order[4];
  bit   got[$];
  int   cnt_before;
  bit   saw_start;
  int   pushed;

  initial begin
    // Single job pushed at E0, done on the third WAIT sample, then spurious-done / clear interplay.
    tbl[0] = '{1, 1, 0, 0,  0, 0, 0, 1, 0, 0};
    tbl[1] = '{0, 0, 0, 0,  1, 1, 1, 1, 0, 0};
    tbl[2] = '{0, 0, 0, 0,  0, 1, 1, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0,  0, 1, 1, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 0,  0, 1, 1, 0, 0, 0};
    tbl[5] = '{0, 0, 1, 0,  0, 1, 1, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 0,  0, 0, 1, 0, 1, 0};
    tbl[7] = '{0, 0, 1, 0,  0, 0, 1, 0, 1, 1};
    tbl[8] = '{0, 0, 1, 1,  0, 0, 1, 0, 1, 1};
    tbl[9] = '{0, 0, 0, 1,  0, 0, 1, 0, 1, 0};
    fill_modes = '{0, 1, 1, 0, 1};
    exp_order  = '{0, 1, 1, 0};

    reset = 1'b1;
    drive(0, 0, 0, 0);
    #1;
    model_reset();
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    check_all();
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].m, tbl[i].d, tbl[i].c);
      step();
      chk($sformatf("tbl%0d_start", i), start, tbl[i].e_start);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_mode", i), mode, tbl[i].e_mode);
      chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].e_level);
      chk($sformatf("tbl%0d_count", i), completed_count, tbl[i].e_count);
      chk($sformatf("tbl%0d_spurious", i), err_spurious, tbl[i].e_sp);
    end

    // Queue fill while blocked in WAIT; the fifth push must be refused.
    drive(1, 1, 0, 0); step();
    drive(0, 0, 0, 0); step(); step();
    for (int i = 0; i < 5; i++) begin
      drive(1, fill_modes[i], 0, 0);
      step();
      if (i == 3) chk("fill_ready_low", cmd_ready, 0);
    end
    chk("fill_level", fifo_level, 4);
    drive(0, 0, 1, 0); step();
    got.delete();
    serve(40, got);
    chk("fill_issued", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("fill_order%0d", i), got[i], exp_order[i]);

    // Watchdog: eight WAIT samples without done abandon the job uncounted.
    cnt_before = m_jobs;
    drive(1, 0, 0, 0); step();
    drive(1, 1, 0, 0); step();
    drive(0, 0, 0, 0); step();
    for (int k = 1; k <= TIMEOUT; k++) begin
      step();
      if (k == TIMEOUT - 1) chk("timeout_not_yet", err_timeout, 0);
    end
    chk("timeout_flag", err_timeout, 1);
    chk("timeout_uncounted", completed_count, cnt_before);
    got.delete();
    serve(12, got);
    chk("timeout_next_issued", got.size(), 1);
    chk("timeout_next_mode", (got.size() > 0) ? got[0] : 1'bx, 1);
    drive(0, 0, 0, 1); step();
    chk("timeout_cleared", err_timeout, 0);

    // Done held high long after completion: one count, no new start, no spurious flag.
    cnt_before = m_jobs;
    drive(1, 1, 0, 0); step();
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 0); step();
    saw_start = 0;
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, 1, 0); step();
      if (start) saw_start = 1;
    end
    chk("stuck_no_start", saw_start, 0);
    chk("stuck_count", completed_count, cnt_before + 1);
    chk("stuck_no_spurious", err_spurious, 0);
    chk("stuck_busy", busy, 1);
    got.delete();
    serve(12, got);
    chk("stuck_next_issued", got.size(), 1);

    // Reset mid-WAIT with three jobs queued.
    drive(1, 1, 0, 0); step();
    drive(1, 0, 0, 0); step();
    drive(1, 1, 0, 0); step();
    drive(1, 0, 0, 0); step();
    chk("pre_reset_level", fifo_level, 3);
    drive(0, 0, 0, 0);
    do_reset();
    chk("rst_start", start, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", completed_count, 0);
    saw_start = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (start) saw_start = 1;
    end
    chk("rst_no_start", saw_start, 0);

    // Five completions: the 2-bit counter wraps to 1.
    pushed = 0;
    for (int k = 0; k < 60; k++) begin
      drive(pushed < 5, k[0], m_stage == ST_WAIT, 0);
      if (pushed < 5 && m_q.size() < DEPTH) pushed++;
      step();
    end
    chk("wrap_count8", completed_count, 5);
    chk("wrap_count2", w_count, 1);

    // Random traffic against the model, with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      if (k % 500 == 250) do_reset();
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
